// File: rtl/reduce_pipe.sv
// -----------------------------------------------------------------------------
// reduce_pipe
//   Pipelined bitwise reduction of a WIDTH-bit operand to a single bit.
//   A balanced binary tree of 2-input cells, log2(WIDTH) levels deep, with a
//   register stage behind every level. Each stage carries a valid bit, its
//   partial results, the operand's op and its tag, so results leave in
//   acceptance order, one per cycle, exactly L cycles after acceptance.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset, clears every stage
//   flush      synchronous clear of all stage valid bits
//   in_valid   operand present on in_data / in_op / in_tag
//   in_ready   operand accepted this cycle when in_valid is also high
//   in_data    WIDTH bits to reduce
//   in_op      00 AND, 01 OR, 10 XOR, 11 NAND
//   in_tag     sideband, returned unchanged with the result
//   out_valid  result present on out_data / out_tag
//   out_ready  consumer takes the result this cycle
//   out_data   reduction result
//   out_tag    tag of the operand that produced out_data
// -----------------------------------------------------------------------------
module reduce_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam int L  = $clog2(WIDTH);
  // Level k holds WIDTH>>(k+1) bits; all levels packed together need WIDTH-1.
  localparam int PW = WIDTH - 1;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

  logic [L-1:0]     valid_q, valid_d;
  op_e              op_q  [L];
  op_e              op_d  [L];
  logic [TAG_W-1:0] tag_q [L];
  logic [TAG_W-1:0] tag_d [L];
  logic [PW-1:0]    part_q, part_d;

  logic advance;
  logic accept;

  // The whole pipe moves together: only a result held at the output stalls it.
  assign advance  = ~(out_valid & ~out_ready);
  assign in_ready = rst_n & advance & ~flush;
  assign accept   = in_valid & in_ready;

  for (genvar k = 0; k < L; k++) begin : g_stage
    localparam int NO  = WIDTH >> (k + 1);     // cells in this level
    localparam int OFF = WIDTH - (WIDTH >> k); // bit offset inside part_*

    logic [2*NO-1:0]  src;
    logic             src_valid;
    op_e              src_op;
    logic [TAG_W-1:0] src_tag;
    logic [NO-1:0]    even_bits, odd_bits, res;

    if (k == 0) begin : g_first
      assign src       = in_data;
      assign src_valid = accept;
      assign src_op    = op_e'(in_op);
      assign src_tag   = in_tag;
    end else begin : g_next
      assign src       = part_q[(WIDTH - (WIDTH >> (k - 1))) +: (2 * NO)];
      assign src_valid = valid_q[k-1];
      assign src_op    = op_q[k-1];
      assign src_tag   = tag_q[k-1];
    end

    for (genvar i = 0; i < NO; i++) begin : g_pair
      assign even_bits[i] = src[2*i];
      assign odd_bits[i]  = src[2*i+1];
    end

    // NAND shares the AND tree; its inversion happens once, at the output.
    always_comb begin
      // NOTE: the default arm assigns res on every path, so no latch is inferred.
      case (src_op)
        OP_OR:   res = even_bits | odd_bits;
        OP_XOR:  res = even_bits ^ odd_bits;
        default: res = even_bits & odd_bits;
      endcase
    end

    assign part_d[OFF +: NO] = advance ? res : part_q[OFF +: NO];
    // NOTE: flush wins over both stall and acceptance; only valid bits clear,
    // stale data left behind is never observed.
    assign valid_d[k] = flush ? 1'b0 : (advance ? src_valid : valid_q[k]);
    assign op_d[k]    = advance ? src_op  : op_q[k];
    assign tag_d[k]   = advance ? src_tag : tag_q[k];
  end

  // NOTE: state is updated with non-blocking assignments so every stage
  // samples its neighbour's pre-edge value; reset clears datapath registers too
  // so outputs read 0 while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      part_q  <= '0;
      op_q    <= '{default: OP_AND};
      tag_q   <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      part_q  <= part_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
    end
  end

  assign out_valid = valid_q[L-1];
  assign out_tag   = tag_q[L-1];
  assign out_data  = part_q[PW-1] ^ (op_q[L-1] == OP_NAND);

endmodule

// File: tb/tb_reduce_pipe.sv
// -----------------------------------------------------------------------------
// tb_reduce_pipe
//   Drives three builds of reduce_pipe (WIDTH 8, 2 and 64) from one shared
//   stimulus stream. Each build has a slot-per-stage reference whose results
//   come straight from whole-word reduction arithmetic; a per-build compare
//   process checks in_ready, out_valid, out_data and out_tag every cycle.
//   Directed sequences with literal expectations on the WIDTH=8 build pin the
//   reference, followed by a long randomized run.
// -----------------------------------------------------------------------------
module tb_reduce_pipe;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic [63:0]      in_data;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole-word reduction of the low w bits of d.
  function automatic logic golden(input logic [63:0] d, input int w, input logic [1:0] op);
    logic [63:0] m;
    logic        all1, any1, par;
    m    = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    all1 = ((d & m) == m);
    any1 = ((d & m) != 64'd0);
    par  = ^(d & m);
    case (op)
      2'b00:   return all1;
      2'b01:   return any1;
      2'b10:   return par;
      default: return !all1;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int W = (g == 0) ? 8 : ((g == 1) ? 2 : 64);
    localparam int L = $clog2(W);

    logic             ir, ov, od;
    logic [TAG_W-1:0] ot;

    reduce_pipe #(.WIDTH(W), .TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (ir),
      .in_data   (in_data[W-1:0]),
      .in_op     (in_op),
      .in_tag    (in_tag),
      .out_valid (ov),
      .out_ready (out_ready),
      .out_data  (od),
      .out_tag   (ot)
    );

    // Reference: L slots, each holding an operand's final answer and tag.
    logic             mv [L];
    logic             md [L];
    logic [TAG_W-1:0] mt [L];
    logic             exp_ir;

    assign exp_ir = rst_n && !flush && !(mv[L-1] && !out_ready);

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < L; k++) begin
          mv[k] <= 1'b0;
          md[k] <= 1'b0;
          mt[k] <= '0;
        end
      end else if (flush) begin
        for (int k = 0; k < L; k++) mv[k] <= 1'b0;
      end else if (!(mv[L-1] && !out_ready)) begin
        for (int k = L - 1; k > 0; k--) begin
          mv[k] <= mv[k-1];
          md[k] <= md[k-1];
          mt[k] <= mt[k-1];
        end
        mv[0] <= in_valid && exp_ir;
        md[0] <= golden(in_data, W, in_op);
        mt[0] <= in_tag;
      end
    end

    always @(negedge clk) begin
      check($sformatf("w%0d_in_ready", W), ir, exp_ir);
      check($sformatf("w%0d_out_valid", W), ov, mv[L-1]);
      if (mv[L-1] || !rst_n) begin
        check($sformatf("w%0d_out_data", W), od, md[L-1]);
        check($sformatf("w%0d_out_tag", W), ot, mt[L-1]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic [1:0] op,
                       input logic [TAG_W-1:0] tag);
    in_valid = v;
    in_data  = d;
    in_op    = op;
    in_tag   = tag;
  endtask

  logic [63:0] bb_data [4];
  logic [1:0]  bb_op   [4];
  logic        bb_exp  [4];

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 64'd0, 2'b00, 4'd0);
    bb_data = '{64'hFE, 64'h00, 64'h07, 64'hFF};
    bb_op   = '{2'b00, 2'b01, 2'b10, 2'b11};
    bb_exp  = '{1'b0, 1'b0, 1'b1, 1'b0};

    // Reset state
    tick();
    tick();
    check("rst_out_valid", g_cfg[0].ov, 1'b0);
    check("rst_out_data",  g_cfg[0].od, 1'b0);
    check("rst_out_tag",   g_cfg[0].ot, 4'd0);
    check("rst_in_ready",  g_cfg[0].ir, 1'b0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", g_cfg[0].ir, 1'b1);

    // Single operand: AND of 8'hFF, tag 3, valid for one cycle, 3 cycles later
    drive(1'b1, 64'hFF, 2'b00, 4'd3);
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) in_valid = 1'b0;
      check("lat_out_valid", g_cfg[0].ov, (c == 3));
      if (c == 3) begin
        check("lat_out_data", g_cfg[0].od, 1'b1);
        check("lat_out_tag",  g_cfg[0].ot, 4'd3);
      end
    end

    // Back-to-back, one per op
    for (int c = 1; c <= 7; c++) begin
      if (c <= 4) drive(1'b1, bb_data[c-1], bb_op[c-1], 4'(c - 1));
      else        in_valid = 1'b0;
      tick();
      if (c >= 3 && c <= 6) begin
        check("b2b_out_valid", g_cfg[0].ov, 1'b1);
        check("b2b_out_data",  g_cfg[0].od, bb_exp[c-3]);
        check("b2b_out_tag",   g_cfg[0].ot, 64'(c - 3));
      end else begin
        check("b2b_idle", g_cfg[0].ov, 1'b0);
      end
    end

    // Stall with in_valid held
    drive(1'b1, 64'h01, 2'b10, 4'd5);
    tick();
    drive(1'b1, 64'h03, 2'b10, 4'd6);
    tick();
    drive(1'b1, 64'h0F, 2'b01, 4'd7);
    tick();
    check("stall_first_tag", g_cfg[0].ot, 4'd5);
    out_ready = 1'b0;
    #1;
    check("stall_in_ready", g_cfg[0].ir, 1'b0);
    for (int c = 0; c < 2; c++) begin
      tick();
      check("stall_hold_valid", g_cfg[0].ov, 1'b1);
      check("stall_hold_data",  g_cfg[0].od, 1'b1);
      check("stall_hold_tag",   g_cfg[0].ot, 4'd5);
      check("stall_hold_ready", g_cfg[0].ir, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    check("resume_tag6",  g_cfg[0].ot, 4'd6);
    check("resume_data6", g_cfg[0].od, 1'b0);
    tick();
    check("resume_tag7",  g_cfg[0].ot, 4'd7);
    in_valid = 1'b0;
    for (int c = 0; c < 8; c++) tick();

    // Flush with three in flight and in_valid high
    for (int c = 1; c <= 3; c++) begin
      drive(1'b1, 64'hFF, 2'b00, 4'(8 + c));
      tick();
    end
    drive(1'b1, 64'hFF, 2'b00, 4'd12);
    flush = 1'b1;
    #1;
    check("flush_in_ready", g_cfg[0].ir, 1'b0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("flush_out_valid", g_cfg[0].ov, 1'b0);
      tick();
    end
    drive(1'b1, 64'h80, 2'b01, 4'd13);
    for (int c = 1; c <= 3; c++) begin
      tick();
      in_valid = 1'b0;
      check("post_flush_valid", g_cfg[0].ov, (c == 3));
    end
    check("post_flush_tag", g_cfg[0].ot, 4'd13);
    for (int c = 0; c < 8; c++) tick();

    // One-cycle reset with the pipeline full
    drive(1'b1, 64'hFF, 2'b00, 4'd9);
    for (int c = 0; c < 4; c++) tick();
    check("pre_rst_valid", g_cfg[0].ov, 1'b1);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("mid_rst_valid", g_cfg[0].ov, 1'b0);
    check("mid_rst_data",  g_cfg[0].od, 1'b0);
    check("mid_rst_tag",   g_cfg[0].ot, 4'd0);
    check("mid_rst_ready", g_cfg[0].ir, 1'b0);
    tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", g_cfg[0].ir, 1'b1);
    for (int c = 0; c < 8; c++) begin
      tick();
      check("post_rst_valid", g_cfg[0].ov, 1'b0);
    end

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      case ($urandom_range(0, 3))
        0:       in_data = {$urandom, $urandom};
        1:       in_data = '1;
        2:       in_data = ~(64'd1 << $urandom_range(0, 63));
        default: in_data = 64'd1 << $urandom_range(0, 63);
      endcase
      in_valid  = ($urandom_range(0, 3) != 0);
      in_op     = 2'($urandom_range(0, 3));
      in_tag    = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 49) == 0);
      tick();
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reduce_pipe.md
REDUCE_PIPE -- requirements
Module: reduce_pipe

Interface
REQ-001 Parameter WIDTH, default 32, number of input bits reduced; power of two, 2..64.
REQ-002 Parameter TAG_W, default 4, width of the sideband tag carried alongside each operand.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 flush  input  1  synchronous pipeline clear.
REQ-006 in_valid  input  1  operand present on in_data/in_op/in_tag.
REQ-007 in_ready  output  1  block accepts operand this cycle.
REQ-008 in_data  input  WIDTH  bits to reduce.
REQ-009 in_op  input  2  reduction mode: 00 AND, 01 OR, 10 XOR, 11 NAND.
REQ-010 in_tag  input  TAG_W  sideband, returned unchanged with the result.
REQ-011 out_valid  output  1  result present on out_data/out_tag.
REQ-012 out_ready  input  1  consumer takes result this cycle.
REQ-013 out_data  output  1  reduction result.
REQ-014 out_tag  output  TAG_W  tag of the operand producing out_data.

Function
REQ-015 Block SHALL be a balanced binary tree of 2-input cells, L = log2(WIDTH) levels, with a register stage after every level.
REQ-016 Each stage SHALL hold a valid bit, partial results, op and tag; op and tag travel with their operand.
REQ-017 Level cell SHALL be AND for op 00/11, OR for 01, XOR for 10; NAND inversion SHALL be applied only at the last level.
REQ-018 stall = out_valid AND NOT out_ready; advance = NOT stall.
REQ-019 in_ready SHALL equal advance AND NOT flush (combinational, no dependence on in_valid).
REQ-020 Operand accepted when in_valid AND in_ready; on advance, stage 0 loads valid = accepted.
REQ-021 On advance every stage k>0 SHALL load stage k-1 (valid, data, op, tag); on stall all stages hold, including bubbles.
REQ-022 Latency SHALL be exactly L cycles from acceptance edge to out_valid high, given no stall; throughput one result per cycle.
REQ-023 out_data/out_tag SHALL be stable while out_valid AND NOT out_ready.
REQ-024 Result consumed on out_valid AND out_ready; same-cycle consume and new acceptance SHALL both occur.
REQ-025 flush high SHALL clear every stage valid bit at the next edge, overriding stall and acceptance; data registers may keep stale values; out_valid low the cycle after flush.
REQ-026 WIDTH=2 SHALL give L=1 (single register stage).
REQ-027 No other state (no counters, no FSM beyond valid bits); order of results SHALL equal order of acceptance.

Reset
REQ-028 rst_n low SHALL immediately clear all valid bits, partial results, op and tag registers to 0; out_valid=0, out_data=0, out_tag=0.
REQ-029 in_ready SHALL be 0 while rst_n low, 1 from first cycle after deassertion (out_valid=0 so no stall).
REQ-030 Reset asserted mid-operation SHALL discard all in-flight operands; none emerge after release.

Verification
REQ-031 WIDTH=8: accept in_data=8'hFF, op=00, tag=3 with out_ready=1 -> out_valid=1, out_data=1, out_tag=3 exactly 3 cycles later, one cycle only.
REQ-032 WIDTH=8 back-to-back: 8'hFE/00, 8'h00/01, 8'h07/10, 8'hFF/11, tags 0..3 -> results 0,0,1,0 on four consecutive cycles, tags 0..3 in order.
REQ-033 Stall: out_ready=0 when first result valid, in_valid held -> in_ready=0, out_data/out_tag frozen; release out_ready -> results resume, none lost or duplicated.
REQ-034 Flush with three operands in flight and in_valid=1 -> operand that cycle not accepted, out_valid stays 0 afterwards until a new operand completes L cycles later.
REQ-035 rst_n pulsed low for one cycle with pipeline full -> all outputs 0 immediately, no results after release, in_ready=1 next cycle.
REQ-036 WIDTH=2 and WIDTH=64 builds: random operands, all ops, random out_ready -> every result matches golden reduction, latency L=1 and 6 respectively.
